// File: rtl/mlu_seq.sv
// Multi-cycle bit-sliced MLU: processes one SLICE_W-bit slice per clock, LSB first,
// with a registered carry between slices and full-word C/Z/N/V flags on completion.
package common;
    localparam logic [2:0] MLU_ADD  = 3'd0;
    localparam logic [2:0] MLU_SUB  = 3'd1;
    localparam logic [2:0] MLU_AND  = 3'd2;
    localparam logic [2:0] MLU_OR   = 3'd3;
    localparam logic [2:0] MLU_XOR  = 3'd4;
    localparam logic [2:0] MLU_NOT  = 3'd5;
    localparam logic [2:0] MLU_ANOT = 3'd6;
    localparam logic [2:0] MLU_NOP1 = 3'd7;
endpackage

module mlu_seq #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_c_out,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_ovf,
    output logic             o_busy
);
    import common::*;

    localparam int NSLICES = WIDTH / SLICE_W;
    localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam int SW1     = SLICE_W + 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_out_valid;
    logic               r_c_out;
    logic               r_zero;
    logic               r_neg;
    logic               r_ovf;
    logic               r_busy;

    logic [SLICE_W-1:0] w_a_sl;
    logic [SLICE_W-1:0] w_b_sl;
    logic [SLICE_W-1:0] w_bk_sl;
    logic [SW1-1:0]     w_sum;
    logic [SLICE_W-1:0] w_slice;
    logic               w_carry_next;
    logic               w_is_sub;
    logic               w_is_arith;
    logic               w_bk_msb;
    logic [WIDTH-1:0]   w_result_next;

    always_comb begin
        w_a_sl        = r_a[int'(r_cnt)*SLICE_W +: SLICE_W];
        w_b_sl        = r_b[int'(r_cnt)*SLICE_W +: SLICE_W];
        w_is_sub      = (r_op == MLU_SUB);
        w_is_arith    = (r_op == MLU_ADD) || w_is_sub;
        w_bk_sl       = w_is_sub ? ~w_b_sl : w_b_sl;
        w_sum         = {1'b0, w_a_sl} + {1'b0, w_bk_sl} + SW1'(r_carry);
        w_bk_msb      = w_is_sub ? ~r_b[WIDTH-1] : r_b[WIDTH-1];
        w_slice       = '0;
        w_carry_next  = r_carry;
        case (r_op)
            MLU_ADD, MLU_SUB: begin
                w_slice      = w_sum[SLICE_W-1:0];
                w_carry_next = w_sum[SLICE_W];
            end
            MLU_AND:  w_slice = w_a_sl & w_b_sl;
            MLU_OR:   w_slice = w_a_sl | w_b_sl;
            MLU_XOR:  w_slice = w_a_sl ^ w_b_sl;
            MLU_NOT:  w_slice = ~w_a_sl;
            MLU_ANOT: w_slice = w_a_sl & ~w_b_sl;
            default:  w_slice = '0;
        endcase
        w_result_next = r_result;
        w_result_next[int'(r_cnt)*SLICE_W +: SLICE_W] = w_slice;
    end

    // Flags are taken from w_result_next on the last RUN cycle, so they cover the final slice.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_c_out     <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_op     <= i_op;
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_carry  <= i_c_in;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= w_carry_next;
                    if (r_cnt == LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_c_out     <= w_is_arith & w_carry_next;
                        r_zero      <= (w_result_next == '0);
                        r_neg       <= w_result_next[WIDTH-1];
                        r_ovf       <= w_is_arith && (r_a[WIDTH-1] == w_bk_msb) &&
                                       (w_result_next[WIDTH-1] != r_a[WIDTH-1]);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE) && !i_rst;
    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_c_out     = r_c_out;
    assign o_zero      = r_zero;
    assign o_neg       = r_neg;
    assign o_ovf       = r_ovf;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_mlu_seq.sv
// Directed-vector bench for mlu_seq at WIDTH=16, SLICE_W=4: table of ops plus
// backpressure and mid-operation reset sequences.
module tb_mlu_seq;
    import common::*;

    localparam int WIDTH   = 16;
    localparam int SLICE_W = 4;
    localparam int NSL     = WIDTH / SLICE_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    mlu_seq #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op(op), .i_a(a), .i_b(b), .i_c_in(c_in),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result),
        .o_c_out(c_out), .o_zero(zero), .o_neg(neg), .o_ovf(ovf), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             z;
        logic             n;
        logic             o;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench #1 after the edge where out_valid was first seen high.
    task automatic wait_out(input string name, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({name, ".latency"}, lat, exp_lat);
    endtask

    task automatic chk_flags(input vec_t v);
        chk({v.name, ".out_valid"}, out_valid, 1);
        chk({v.name, ".result"}, result, v.res);
        chk({v.name, ".c_out"}, c_out, v.c);
        chk({v.name, ".zero"}, zero, v.z);
        chk({v.name, ".neg"}, neg, v.n);
        chk({v.name, ".ovf"}, ovf, v.o);
        $display("op %-8s a=%04h b=%04h cin=%0d -> res=%04h c=%0d z=%0d n=%0d v=%0d",
                 v.name, v.a, v.b, v.cin, result, c_out, zero, neg, ovf);
    endtask

    task automatic start_op(input vec_t v);
        int n = 0;
        op = v.op; a = v.a; b = v.b; c_in = v.cin; in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk({v.name, ".ready_wait"}, (n < 40), 1);
        tick();
        in_valid = 1'b0;
        op = 3'd0; a = '0; b = '0; c_in = 1'b0;
        chk({v.name, ".busy"}, busy, 1);
        chk({v.name, ".in_ready_low"}, in_ready, 0);
    endtask

    task automatic handoff(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, ".valid_drop"}, out_valid, 0);
        chk({name, ".idle_ready"}, in_ready, 1);
        chk({name, ".idle_busy"}, busy, 0);
    endtask

    function automatic vec_t mk(input string nm, input logic [2:0] o_, input logic [15:0] a_,
                                input logic [15:0] b_, input logic ci, input logic [15:0] r_,
                                input logic c_, input logic z_, input logic n_, input logic v_);
        vec_t v;
        v.name = nm; v.op = o_; v.a = a_; v.b = b_; v.cin = ci;
        v.res = r_; v.c = c_; v.z = z_; v.n = n_; v.o = v_;
        return v;
    endfunction

    initial begin
        vec_t v;
        vecs[0]  = mk("add_ff",   MLU_ADD,  16'h00FF, 16'h0001, 1'b0, 16'h0100, 0, 0, 0, 0);
        vecs[1]  = mk("sub_eq",   MLU_SUB,  16'h0005, 16'h0005, 1'b1, 16'h0000, 1, 1, 0, 0);
        vecs[2]  = mk("sub_brw",  MLU_SUB,  16'h0000, 16'h0001, 1'b1, 16'hFFFF, 0, 0, 1, 0);
        vecs[3]  = mk("add_ovf",  MLU_ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 0, 1, 1);
        vecs[4]  = mk("add_wrap", MLU_ADD,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 1, 0, 0);
        vecs[5]  = mk("and",      MLU_AND,  16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 0, 0, 1, 0);
        vecs[6]  = mk("or",       MLU_OR,   16'hF0F0, 16'hFF00, 1'b0, 16'hFFF0, 0, 0, 1, 0);
        vecs[7]  = mk("xor",      MLU_XOR,  16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0, 0, 0, 0, 0);
        vecs[8]  = mk("not",      MLU_NOT,  16'hF0F0, 16'hFF00, 1'b0, 16'h0F0F, 0, 0, 0, 0);
        vecs[9]  = mk("anot",     MLU_ANOT, 16'hF0F0, 16'hFF00, 1'b0, 16'h00F0, 0, 0, 0, 0);
        vecs[10] = mk("nop1",     MLU_NOP1, 16'hF0F0, 16'hFF00, 1'b1, 16'h0000, 0, 1, 0, 0);
        vecs[11] = mk("add_cin",  MLU_ADD,  16'h0001, 16'h0002, 1'b1, 16'h0004, 0, 0, 0, 0);
        vecs[12] = mk("sub_novf", MLU_SUB,  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1, 0, 0, 1);
        vecs[13] = mk("and_cin",  MLU_AND,  16'hFFFF, 16'h0FFF, 1'b1, 16'h0FFF, 0, 0, 0, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = '0; b = '0; c_in = 1'b0;
        #1;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", result, 0);
        chk("rst.busy", busy, 0);
        chk("rst.flags", {c_out, zero, neg, ovf}, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst.release_ready", in_ready, 1);

        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i]);
            wait_out(vecs[i].name, NSL);
            chk_flags(vecs[i]);
            handoff(vecs[i].name);
        end

        // Backpressure: DONE held three cycles while a new request waits on the inputs.
        v = mk("bp_first", MLU_ADD, 16'h1234, 16'h1111, 1'b0, 16'h2345, 0, 0, 0, 0);
        start_op(v);
        wait_out(v.name, NSL);
        chk_flags(v);
        op = MLU_SUB; a = 16'h0010; b = 16'h0001; c_in = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp.hold_valid", out_valid, 1);
            chk("bp.hold_result", result, 16'h2345);
            chk("bp.hold_flags", {c_out, zero, neg, ovf}, 0);
            chk("bp.hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.handoff_valid", out_valid, 0);
        chk("bp.handoff_ready", in_ready, 1);
        chk("bp.handoff_busy", busy, 0);
        tick();
        in_valid = 1'b0;
        chk("bp.accept_busy", busy, 1);
        chk("bp.accept_ready", in_ready, 0);
        v = mk("bp_second", MLU_SUB, 16'h0010, 16'h0001, 1'b1, 16'h000F, 1, 0, 0, 0);
        wait_out(v.name, NSL);
        chk_flags(v);
        handoff(v.name);

        // Reset two RUN cycles into an ADD; the partial result is nonzero by then.
        v = mk("rst_mid", MLU_ADD, 16'h1234, 16'h1111, 1'b0, 16'h2345, 0, 0, 0, 0);
        start_op(v);
        tick();
        tick();
        chk("rstmid.partial_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rstmid.result", result, 0);
        chk("rstmid.busy", busy, 0);
        chk("rstmid.out_valid", out_valid, 0);
        chk("rstmid.flags", {c_out, zero, neg, ovf}, 0);
        chk("rstmid.in_ready_in_rst", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid.in_ready_after", in_ready, 1);
        chk("rstmid.valid_after", out_valid, 0);
        v = mk("post_rst", MLU_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 0, 0, 0, 0);
        start_op(v);
        wait_out(v.name, NSL);
        chk_flags(v);
        handoff(v.name);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mlu_seq.md
Name: mlu_seq

Overview:
Multi-cycle, parametrised MLU. It processes a WIDTH-bit operand pair one SLICE_W-bit slice per clock, LSB first, with a registered carry chain between slices. It computes the same op set as the single-slice MLU and adds full-word flags: carry, zero, negative and signed overflow. It sits between the register file and the writeback mux and uses valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SLICE_W.
SLICE_W, 4, bits processed per cycle; NSLICES = WIDTH/SLICE_W, and NSLICES >= 1.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous reset, active-high.
IN_VALID  input  1  operation request.
IN_READY  output  1  block can accept a request.
OP  input  3  common::MLU_* opcode: ADD, SUB, AND, OR, XOR, NOT, ANOT, NOP1.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
C_IN  input  1  carry-in for ADD/SUB. Caller drives 1 for a plain SUB; this allows multi-word chaining.
OUT_VALID  output  1  result and flags valid.
OUT_READY  input  1  consumer accepts the result.
RESULT  output  WIDTH  result word.
C_OUT  output  1  carry out of the MSB (ADD/SUB); 0 for all other ops.
ZERO  output  1  RESULT == 0.
NEG  output  1  RESULT[WIDTH-1].
OVF  output  1  signed overflow (ADD/SUB); 0 for all other ops.
BUSY  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE; slice counter=0; operand, carry and result registers=0; OUT_VALID=0; RESULT=0; C_OUT=0; ZERO=0; NEG=0; OVF=0; BUSY=0. Any in-flight op is dropped silently.
- IN_READY = (state==IDLE) && !RST. It is combinational and does not depend on IN_VALID.
- IDLE: on IN_VALID && IN_READY, latch OP, A and B, load carry=C_IN, clear counter and result, go to RUN. OP, A and B are ignored at any other time.
- RUN:
  - Cycle k (k = 0..NSLICES-1) computes slice k from the latched operands.
  - Let Bk be B[k] for ADD and ~B[k] for SUB.
  - ADD/SUB: sum = A[k] + Bk + carry, computed SLICE_W+1 bits wide. The low SLICE_W bits are written to RESULT slice k; bit SLICE_W becomes the next carry.
  - AND, OR, XOR, NOT (~A), ANOT (A & ~B): bitwise, carry unchanged. NOP1 writes 0.
  - After slice NSLICES-1, go to DONE.
- DONE:
  - OUT_VALID=1. RESULT and flags are stable and hold until OUT_READY is sampled high.
  - On OUT_VALID && OUT_READY, go to IDLE. IN_READY rises the following cycle; there is no accept in the same cycle as the handoff.
- Latency: accept edge at cycle t; OUT_VALID high from cycle t+NSLICES. Throughput is at most one op per NSLICES+2 cycles.
- Flags, computed when entering DONE:
  - C_OUT = final carry (ADD/SUB only).
  - ZERO = RESULT==0, for every op, including NOP1 (ZERO=1).
  - NEG = MSB of RESULT.
  - OVF = (A[msb]==Bk[msb]) && (RESULT[msb]!=A[msb]), where Bk is B for ADD and ~B for SUB.
- SUB with C_IN=1 gives A-B. C_OUT=1 means no borrow.
- Arithmetic wraps modulo 2^WIDTH.
- NSLICES=1: RUN lasts exactly one cycle.
- IN_VALID held high while busy has no effect; it is accepted only on return to IDLE.
- Outputs are registered; none depends combinationally on A, B, OP or OUT_READY.

Test Plan:
(Bench runs WIDTH=16, SLICE_W=4.)
1. ADD A=0x00FF, B=0x0001, C_IN=0 -> after 4 RUN cycles RESULT=0x0100, C_OUT=0, ZERO=0, NEG=0, OVF=0.
2. SUB A=0x0005, B=0x0005, C_IN=1 -> RESULT=0x0000, ZERO=1, C_OUT=1, OVF=0. Then SUB A=0x0000, B=0x0001, C_IN=1 -> RESULT=0xFFFF, C_OUT=0, NEG=1.
3. ADD A=0x7FFF, B=0x0001, C_IN=0 -> RESULT=0x8000, OVF=1, NEG=1, C_OUT=0. Then ADD A=0xFFFF, B=0x0001 -> RESULT=0x0000, C_OUT=1, ZERO=1.
4. Logic ops on A=0xF0F0, B=0xFF00:
   - AND -> 0xF000; OR -> 0xFFF0; XOR -> 0x0FF0; NOT -> 0x0F0F; ANOT -> 0x00F0.
   - NOP1 -> 0x0000 with ZERO=1.
   - C_OUT=0 and OVF=0 for all.
5. Backpressure: hold OUT_READY low for 3 cycles in DONE with IN_VALID high and new operands applied.
   - RESULT and flags stay constant; IN_READY=0 throughout.
   - The new op is accepted one cycle after OUT_READY goes high.
6. Assert RST after 2 RUN cycles of ADD 0x1234+0x1111.
   - All outputs go to 0 immediately; state returns to IDLE and IN_READY=1 after release.
   - A following ADD 0x0001+0x0001 returns RESULT=0x0002.
